// File: rtl/watch_ctrl_pkg.sv
// Shared types and timing constants for the watch set controller.
// The optional auto-repeat feature is enabled by defining WATCH_AUTOREPEAT_EN.
package watch_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2
  } state_t;

  localparam int SEC_MAX    = 59;
  localparam int REP_DELAY  = 8;
  localparam int REP_PERIOD = 2;
  localparam int BLINK_DIV  = 4;

  localparam int REP_W   = $clog2(REP_DELAY + 1);
  localparam int BLINK_W = $clog2(BLINK_DIV);

endpackage

// File: rtl/btn_press.sv
// Rising-edge press detector with optional hold-to-repeat, paced by tick_rep.
// First repeat fires on the tick after REP_DELAY ticks of holding, then every REP_PERIOD ticks.
module btn_press
  import watch_ctrl_pkg::*;
#(
  parameter bit REPEAT_EN = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  input  logic tick_rep,
  input  logic enable,
  output logic press
);

  logic btn_q;
  logic edge_press;

  // NOTE: the edge register resets to 1 so a button held through reset release
  // is treated as already pressed and produces no spurious press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) btn_q <= 1'b1;
    else        btn_q <= btn;
  end

  assign edge_press = btn & ~btn_q;

  generate
    if (REPEAT_EN) begin : g_repeat
      logic [REP_W-1:0] rep_cnt;
      logic             armed;
      logic             held;
      logic [REP_W-1:0] limit;
      logic             fire;

      assign held  = btn & btn_q;
      assign limit = armed ? REP_W'(REP_PERIOD - 1) : REP_W'(REP_DELAY);
      assign fire  = held & enable & tick_rep & (rep_cnt == limit);

      // NOTE: sequential state always uses non-blocking assignments so every
      // register samples the pre-edge values of its neighbours.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          rep_cnt <= '0;
          armed   <= 1'b0;
        end else if (!held || !enable) begin
          rep_cnt <= '0;
          armed   <= 1'b0;
        end else if (tick_rep) begin
          if (fire) begin
            rep_cnt <= '0;
            armed   <= 1'b1;
          end else begin
            rep_cnt <= rep_cnt + 1'b1;
          end
        end
      end

      assign press = edge_press | fire;
    end else begin : g_no_repeat
      logic unused_rep;
      assign unused_rep = tick_rep & enable;
      assign press      = edge_press;
    end
  endgenerate

endmodule

// File: rtl/watch_set_controller.sv
// Watch mode/set controller: RUN -> SET_HR -> SET_MIN -> RUN, seconds counter and digit blink.
// Define WATCH_AUTOREPEAT_EN to let a held inc button auto-repeat in the set states.
module watch_set_controller
  import watch_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic       tick_sec,
  input  logic       tick_rep,
  output logic       min_tick,
  output logic       stop,
  output logic       hr_inc,
  output logic       min_inc,
  output logic       blink_hr,
  output logic       blink_min,
  output logic [1:0] mode,
  output logic [5:0] sec
);

`ifdef WATCH_AUTOREPEAT_EN
  localparam bit INC_REPEAT = 1'b1;
`else
  localparam bit INC_REPEAT = 1'b0;
`endif

  state_t             state, state_n;
  logic               phase, phase_n;
  logic [BLINK_W-1:0] div, div_n;
  logic [5:0]         sec_n;
  logic               wrap;
  logic               mode_press, inc_press, inc_ok;
  logic               in_set;

  assign in_set = (state == SET_HR) || (state == SET_MIN);

  btn_press #(.REPEAT_EN(1'b0)) u_mode_press (
    .clk      (clk),
    .reset    (reset),
    .btn      (mode_btn),
    .tick_rep (tick_rep),
    .enable   (1'b0),
    .press    (mode_press)
  );

  // Repeat counting is disabled for the cycle of a mode press, which clears it on a state change.
  btn_press #(.REPEAT_EN(INC_REPEAT)) u_inc_press (
    .clk      (clk),
    .reset    (reset),
    .btn      (inc_btn),
    .tick_rep (tick_rep),
    .enable   (in_set & ~mode_press),
    .press    (inc_press)
  );

  // NOTE: every variable assigned here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    phase_n = phase;
    div_n   = div;
    sec_n   = sec;
    wrap    = 1'b0;

    case (state)
      RUN:     if (mode_press) state_n = SET_HR;
      SET_HR:  if (mode_press) state_n = SET_MIN;
      SET_MIN: if (mode_press) state_n = RUN;
      default: state_n = RUN;
    endcase

    // A simultaneous mode press wins; the inc press is dropped.
    inc_ok = inc_press & ~mode_press & in_set;

    if (state_n != state) begin
      phase_n = 1'b1;
      div_n   = '0;
    end else if (inc_ok) begin
      phase_n = 1'b0;
      div_n   = '0;
    end else if (tick_rep) begin
      if (div == BLINK_W'(BLINK_DIV - 1)) begin
        phase_n = ~phase;
        div_n   = '0;
      end else begin
        div_n = div + 1'b1;
      end
    end

    if (state_n == SET_MIN && state != SET_MIN) begin
      sec_n = '0;
    end else if (state == RUN && state_n == RUN && tick_sec) begin
      if (sec == 6'(SEC_MAX)) begin
        sec_n = '0;
        wrap  = 1'b1;
      end else begin
        sec_n = sec + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      phase     <= 1'b1;
      div       <= '0;
      sec       <= '0;
      min_tick  <= 1'b0;
      hr_inc    <= 1'b0;
      min_inc   <= 1'b0;
      stop      <= 1'b0;
      blink_hr  <= 1'b0;
      blink_min <= 1'b0;
    end else begin
      state     <= state_n;
      phase     <= phase_n;
      div       <= div_n;
      sec       <= sec_n;
      min_tick  <= wrap;
      hr_inc    <= inc_ok & (state == SET_HR);
      min_inc   <= inc_ok & (state == SET_MIN);
      stop      <= (state_n != RUN);
      blink_hr  <= (state_n == SET_HR) & phase_n;
      blink_min <= (state_n == SET_MIN) & phase_n;
    end
  end

  assign mode = state;

endmodule

// File: tb/tb_watch_set_controller.sv
// Directed self-checking bench for watch_set_controller; expected auto-repeat
// count follows WATCH_AUTOREPEAT_EN.
module tb_watch_set_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       mode_btn, inc_btn, tick_sec, tick_rep;
  logic       min_tick, stop, hr_inc, min_inc, blink_hr, blink_min;
  logic [1:0] mode;
  logic [5:0] sec;

  int checks = 0;
  int errors = 0;
  int n_hr = 0, n_min = 0, n_tick = 0;
  int b_hr, b_min, b_tick;

`ifdef WATCH_AUTOREPEAT_EN
  localparam int EXP_HELD_INC = 5;
`else
  localparam int EXP_HELD_INC = 1;
`endif

  always #5 clk = ~clk;

  watch_set_controller dut (
    .clk       (clk),
    .reset     (reset),
    .mode_btn  (mode_btn),
    .inc_btn   (inc_btn),
    .tick_sec  (tick_sec),
    .tick_rep  (tick_rep),
    .min_tick  (min_tick),
    .stop      (stop),
    .hr_inc    (hr_inc),
    .min_inc   (min_inc),
    .blink_hr  (blink_hr),
    .blink_min (blink_min),
    .mode      (mode),
    .sec       (sec)
  );

  always @(negedge clk) begin
    if (hr_inc === 1'b1)   n_hr++;
    if (min_inc === 1'b1)  n_min++;
    if (min_tick === 1'b1) n_tick++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic snap();
    b_hr   = n_hr;
    b_min  = n_min;
    b_tick = n_tick;
  endtask

  task automatic press_mode();
    mode_btn = 1'b1; cyc();
    mode_btn = 1'b0; cyc();
  endtask

  task automatic press_inc();
    inc_btn = 1'b1; cyc();
    inc_btn = 1'b0; cyc();
  endtask

  task automatic pulse_sec(input int n);
    for (int i = 0; i < n; i++) begin
      tick_sec = 1'b1; cyc();
      tick_sec = 1'b0; cyc();
    end
  endtask

  task automatic pulse_rep(input int n);
    for (int i = 0; i < n; i++) begin
      tick_rep = 1'b1; cyc();
      tick_rep = 1'b0; cyc();
    end
  endtask

  initial begin
    reset = 1'b0; mode_btn = 1'b0; inc_btn = 1'b0; tick_sec = 1'b0; tick_rep = 1'b0;
    repeat (3) cyc();
    check("rst_mode", mode, 0);
    check("rst_stop", stop, 0);
    check("rst_sec", sec, 0);
    check("rst_pulses", {min_tick, hr_inc, min_inc, blink_hr, blink_min}, 0);

    // Seconds roll over exactly once after 60 ticks.
    reset = 1'b1; cyc();
    snap();
    pulse_sec(59);
    check("sec_59", sec, 59);
    check("no_early_min_tick", n_tick - b_tick, 0);
    tick_sec = 1'b1; cyc();
    check("min_tick_pulse", min_tick, 1);
    check("sec_wrap", sec, 0);
    tick_sec = 1'b0; cyc();
    check("min_tick_one_cycle", min_tick, 0);
    check("min_tick_count", n_tick - b_tick, 1);

    // Hour setting with three presses.
    press_mode();
    check("set_hr_mode", mode, 1);
    check("set_hr_stop", stop, 1);
    check("set_hr_blink", blink_hr, 1);
    snap();
    inc_btn = 1'b1; cyc();
    check("hr_inc_latency", hr_inc, 1);
    check("blink_off_after_inc", blink_hr, 0);
    inc_btn = 1'b0; cyc();
    check("hr_inc_one_cycle", hr_inc, 0);
    press_inc();
    pulse_sec(2);
    press_inc();
    check("hr_inc_count", n_hr - b_hr, 3);
    check("no_min_inc_in_hr", n_min - b_min, 0);
    check("no_min_tick_in_set", n_tick - b_tick, 0);
    check("stop_held", stop, 1);
    press_mode();
    press_mode();
    check("back_to_run", mode, 0);

    // Seconds hold in SET_HR and clear on entering SET_MIN.
    pulse_sec(37);
    check("sec_37", sec, 37);
    press_mode();
    check("sec_hold_hr", sec, 37);
    press_mode();
    check("set_min_mode", mode, 2);
    check("sec_clear_min", sec, 0);
    pulse_sec(3);
    check("sec_hold_min", sec, 0);
    press_mode();
    check("run_mode", mode, 0);
    check("run_stop", stop, 0);

    // Mode and inc rising together: mode wins, inc dropped.
    press_mode();
    snap();
    mode_btn = 1'b1; inc_btn = 1'b1; cyc();
    mode_btn = 1'b0; inc_btn = 1'b0; cyc();
    cyc();
    check("collide_mode", mode, 2);
    check("collide_no_hr", n_hr - b_hr, 0);
    check("collide_no_min", n_min - b_min, 0);

    // Held inc in SET_MIN for 16 repeat ticks.
    snap();
    inc_btn = 1'b1; cyc();
    check("min_inc_latency", min_inc, 1);
    check("min_blink_off", blink_min, 0);
    pulse_rep(16);
    inc_btn = 1'b0; cyc(); cyc();
    check("held_min_inc_count", n_min - b_min, EXP_HELD_INC);
    check("held_no_hr", n_hr - b_hr, 0);
    pulse_rep(4);
    check("blink_toggle", blink_min, 1);
    press_mode();
    check("blink_min_off_run", blink_min, 0);

    // Inc presses ignored in RUN.
    snap();
    press_inc();
    check("run_ignores_inc", (n_hr - b_hr) + (n_min - b_min), 0);

    // Reset mid-set with inc held.
    press_mode();
    check("pre_reset_set_hr", mode, 1);
    inc_btn = 1'b1; cyc(); cyc();
    snap();
    #2 reset = 1'b0;
    #1;
    check("async_reset_mode", mode, 0);
    check("async_reset_stop", stop, 0);
    check("async_reset_blink", blink_hr, 0);
    cyc(); cyc();
    reset = 1'b1;
    pulse_rep(10);
    check("post_reset_no_hr", n_hr - b_hr, 0);
    check("post_reset_no_min", n_min - b_min, 0);
    check("post_reset_mode", mode, 0);
    inc_btn = 1'b0; cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
